// File: rtl/ps2_rx.sv
// Host-side PS/2 receiver: pin synchronisers, clock glitch filter, frame FSM,
// one-entry valid/ready holding register and optional device clock inhibit.
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter bit INHIBIT_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       ps2_clk_inhibit
);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Odd parity: the eight data bits plus the parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    dat_sync_q, dat_sync_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall_q, fall_d;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          parity_err_q, parity_err_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          inhibit_q, inhibit_d;
    logic          tick_s, deliver_s, consume_s;

    // Pin synchronisers and the clock filter that produces the falling-edge tick.
    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk_in};
        dat_sync_d = {dat_sync_q[0], ps2_dat_in};
        filt_d     = filt_q;
        filt_cnt_d = '0;
        fall_d     = 1'b0;
        if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = ~filt_q;
                fall_d = filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end else begin
            filt_cnt_d = '0;
        end
    end

    // Frame FSM with inter-edge timeout; edges are ignored while the host holds the clock low.
    always_comb begin
        tick_s       = fall_q & ~inhibit_q;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        par_d        = par_q;
        to_cnt_d     = '0;
        deliver_s    = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        if (tick_s) begin
            case (state_q)
                IDLE: begin
                    if (!dat_sync_q[1]) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    shreg_d   = {dat_sync_q[1], shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        state_d = DATA;
                    end
                end
                PARITY: begin
                    par_d   = dat_sync_q[1];
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!dat_sync_q[1]) begin
                        frame_err_d = 1'b1;
                    end else if (!odd_parity_ok(shreg_q, par_q)) begin
                        parity_err_d = 1'b1;
                    end else begin
                        deliver_s = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                frame_err_d = 1'b1;
                state_d     = IDLE;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    // Holding register, overrun detection and the clock inhibit request.
    always_comb begin
        consume_s  = rx_valid_q & rx_ready;
        rx_valid_d = rx_valid_q & ~consume_s;
        rx_data_d  = rx_data_q;
        overrun_d  = 1'b0;
        if (deliver_s) begin
            if (!rx_valid_q || consume_s) begin
                rx_valid_d = 1'b1;
                rx_data_d  = shreg_q;
            end else begin
                overrun_d = 1'b1;
            end
        end else begin
            overrun_d = 1'b0;
        end
        // Only raise inhibit between frames so a frame in flight is never cut short.
        if (!INHIBIT_EN || !rx_valid_q) begin
            inhibit_d = 1'b0;
        end else if (state_q == IDLE) begin
            inhibit_d = 1'b1;
        end else begin
            inhibit_d = inhibit_q;
        end
    end

    // All state; reset leaves both lines idle-high and the holding register empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q   <= 2'b11;
            dat_sync_q   <= 2'b11;
            filt_q       <= 1'b1;
            filt_cnt_q   <= '0;
            fall_q       <= 1'b0;
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shreg_q      <= 8'h00;
            par_q        <= 1'b0;
            to_cnt_q     <= '0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            inhibit_q    <= 1'b0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            dat_sync_q   <= dat_sync_d;
            filt_q       <= filt_d;
            filt_cnt_q   <= filt_cnt_d;
            fall_q       <= fall_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            par_q        <= par_d;
            to_cnt_q     <= to_cnt_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            inhibit_q    <= inhibit_d;
        end
    end

    assign rx_data         = rx_data_q;
    assign rx_valid        = rx_valid_q;
    assign parity_err      = parity_err_q;
    assign frame_err       = frame_err_q;
    assign overrun         = overrun_q;
    assign ps2_clk_inhibit = inhibit_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: a frame-level expectation queue plus holding-register model checks
// dut0 (no inhibit) every cycle; dut1 (inhibit enabled) gets directed checks.
module tb_ps2_rx;
    localparam int FILT = 8;
    localparam int TMO  = 1000;
    localparam int HALF = 24;

    localparam logic [1:0] K_GOOD = 2'd0;
    localparam logic [1:0] K_PERR = 2'd1;
    localparam logic [1:0] K_FERR = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ready0 = 1'b0;
    logic       ready1 = 1'b1;
    logic [7:0] rx_data0, rx_data1;
    logic       rx_valid0, rx_valid1, pe0, pe1, fe0, fe1, ov0, ov1, inh0, inh1;
    logic       line1;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   fall_cyc = 0;
    int   load_cyc = 0;
    int   ferr_cyc = 0;
    exp_t exp_q[$];

    // The host's open-drain pull-down wins over the device clock on the shared line.
    assign line1 = dev_clk & ~inh1;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ps2_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO), .INHIBIT_EN(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .ps2_clk_in(dev_clk), .ps2_dat_in(dev_dat),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(ready0),
        .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .ps2_clk_inhibit(inh0)
    );

    ps2_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO), .INHIBIT_EN(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .ps2_clk_in(line1), .ps2_dat_in(dev_dat),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(ready1),
        .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .ps2_clk_inhibit(inh1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Frame as sent on the wire, bit 0 first: start, 8 data bits LSB first, odd parity, stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic bad_par,
                                               input logic stop);
        return {stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            dev_dat = bits[i];
            repeat (HALF / 2) tick();
            dev_clk  = 1'b0;
            fall_cyc = cyc;
            repeat (HALF) tick();
            dev_clk = 1'b1;
            repeat (HALF / 2) tick();
        end
        dev_dat = 1'b1;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        check("event_arrived", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic frame(input logic [7:0] b, input logic bad_par, input logic stop,
                         input logic [1:0] kind);
        exp_t e;
        e.kind = kind;
        e.data = b;
        exp_q.push_back(e);
        send_bits(frame_bits(b, bad_par, stop), 11);
        drain(200);
    endtask

    task automatic consume0();
        ready0 = 1'b1;
        tick();
        ready0 = 1'b0;
    endtask

    // Compare process: every cycle dut0 must match the holding-register model; any
    // pulse or fresh load is matched against the next expected frame outcome.
    initial begin : cmp
        logic       mv, mv_nd, load, ev, prev_ready;
        logic [7:0] md;
        logic [12:0] req;
        exp_t       e;
        mv = 1'b0;
        md = 8'h00;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check("reset_outputs", {rx_data0, rx_valid0, pe0, fe0, ov0, inh0}, 13'd0);
                mv = 1'b0;
                md = 8'h00;
                exp_q.delete();
            end else begin
                mv_nd = mv & ~prev_ready;
                load  = rx_valid0 & ~mv_nd;
                ev    = pe0 | fe0 | ov0 | load;
                req   = {md, mv_nd, 4'b0000};
                if (load) load_cyc = cyc;
                if (fe0) ferr_cyc = cyc;
                if (ev && exp_q.size() == 0) begin
                    check("unexpected_event", {rx_data0, rx_valid0, pe0, fe0, ov0, inh0}, req);
                end else if (ev) begin
                    e = exp_q.pop_front();
                    case (e.kind)
                        K_GOOD: begin
                            if (mv_nd) begin
                                req = {md, 1'b1, 4'b0010};
                            end else begin
                                md    = e.data;
                                mv_nd = 1'b1;
                                req   = {md, 1'b1, 4'b0000};
                            end
                        end
                        K_PERR:  req = {md, mv_nd, 4'b1000};
                        K_FERR:  req = {md, mv_nd, 4'b0100};
                        default: req = {md, mv_nd, 4'b0000};
                    endcase
                    check("frame_outcome", {rx_data0, rx_valid0, pe0, fe0, ov0, inh0}, req);
                end else begin
                    check("steady_state", {rx_data0, rx_valid0, pe0, fe0, ov0, inh0}, req);
                end
                mv = mv_nd;
            end
            prev_ready = ready0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        int t_fall;
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (5) tick();

        check("frame_bits_1C", frame_bits(8'h1C, 1'b0, 1'b1), 11'h438);
        check("frame_bits_F0", frame_bits(8'hF0, 1'b0, 1'b1), 11'h7E0);
        check("inh1_after_reset", inh1, 1'b0);

        // Single frame, latency from the stop-bit edge.
        frame(8'h1C, 1'b0, 1'b1, K_GOOD);
        check("latency_1C", load_cyc - fall_cyc, FILT + 3);
        check("data_1C", {rx_valid0, rx_data0}, {1'b1, 8'h1C});
        consume0();

        // Back-to-back with the consumer always ready.
        ready0 = 1'b1;
        frame(8'hF0, 1'b0, 1'b1, K_GOOD);
        frame(8'h1C, 1'b0, 1'b1, K_GOOD);
        check("b2b_last_data", rx_data0, 8'h1C);
        ready0 = 1'b0;

        // Error frames.
        frame(8'h1C, 1'b1, 1'b1, K_PERR);
        check("perr_no_valid", rx_valid0, 1'b0);
        frame(8'h1C, 1'b0, 1'b0, K_FERR);

        // Clock stops after four data bits.
        exp_q.push_back('{kind: K_FERR, data: 8'h00});
        send_bits(frame_bits(8'h5A, 1'b0, 1'b1), 5);
        t_fall = fall_cyc;
        drain(TMO + 100);
        check("timeout_cycle", ferr_cyc - t_fall, TMO + FILT + 3);
        frame(8'h5A, 1'b0, 1'b1, K_GOOD);
        check("data_5A", {rx_valid0, rx_data0}, {1'b1, 8'h5A});
        consume0();

        // Overrun on the non-inhibiting receiver.
        frame(8'h11, 1'b0, 1'b1, K_GOOD);
        frame(8'h22, 1'b0, 1'b1, K_GOOD);
        check("overrun_keeps_11", {rx_valid0, rx_data0}, {1'b1, 8'h11});
        consume0();

        // Inhibit: dut1 holds 0x11 and pulls its clock line low until consumed.
        ready0 = 1'b1;
        ready1 = 1'b0;
        frame(8'h11, 1'b0, 1'b1, K_GOOD);
        check("dut1_held_11", {rx_valid1, rx_data1}, {1'b1, 8'h11});
        check("inhibit_set", inh1, 1'b1);
        dev_dat = 1'b0;
        repeat (100) tick();
        check("inhibit_hold", {inh1, rx_valid1}, 2'b11);
        ready1 = 1'b1;
        tick();
        ready1 = 1'b0;
        check("consumed_inhibit_still", {inh1, rx_valid1}, 2'b10);
        tick();
        check("inhibit_released", inh1, 1'b0);
        dev_dat = 1'b1;
        repeat (40) tick();
        frame(8'h33, 1'b0, 1'b1, K_GOOD);
        check("dut1_after_release", {rx_valid1, rx_data1, pe1, fe1, ov1}, {1'b1, 8'h33, 3'b000});
        ready1 = 1'b1;
        ready0 = 1'b0;

        // Short low glitch with data low must not start a frame.
        dev_dat = 1'b0;
        dev_clk = 1'b0;
        repeat (5) tick();
        dev_clk = 1'b1;
        repeat (30) tick();
        dev_dat = 1'b1;
        repeat (20) tick();
        frame(8'hC3, 1'b0, 1'b1, K_GOOD);
        check("data_C3", {rx_valid0, rx_data0}, {1'b1, 8'hC3});

        // Reset in the middle of a frame while a byte is held.
        send_bits(frame_bits(8'hA5, 1'b0, 1'b1), 4);
        reset_n = 1'b0;
        #1;
        check("dut1_reset_async", {rx_data1, rx_valid1, pe1, fe1, ov1, inh1}, 13'd0);
        check("dut0_reset_async", {rx_data0, rx_valid0}, 9'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (10) tick();
        frame(8'hA5, 1'b0, 1'b1, K_GOOD);
        check("data_A5_after_reset", {rx_valid0, rx_data0}, {1'b1, 8'hA5});

        repeat (20) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- Host-side PS/2 receiver that deserialises device-to-host frames from the keyboard/mouse PS2_CLK/PS2_DAT lines.
- Presents each byte through a one-entry valid/ready holding register, intended for a Nios II PIO or Avalon-MM wrapper.
- Flags parity, framing, timeout and overrun errors.
- Can inhibit the device by requesting that the clock line be pulled low while an unread byte is held.

Parameters:
- FILTER_LEN, 8: consecutive identical synced samples required before the filtered PS/2 clock changes.
- TIMEOUT_CYCLES, 100000: clk cycles allowed between falling edges inside a frame (2 ms at 50 MHz).
- INHIBIT_EN, 1: 1 = assert ps2_clk_inhibit while the holding register is full; 0 = ps2_clk_inhibit tied 0.

Ports:
- clk, input, 1: system clock, 50 MHz.
- reset_n, input, 1: asynchronous active-low reset.
- ps2_clk_in, input, 1: raw PS/2 clock pin value, asynchronous.
- ps2_dat_in, input, 1: raw PS/2 data pin value, asynchronous.
- rx_data, output, 8: received byte; valid while rx_valid = 1.
- rx_valid, output, 1: holding register full.
- rx_ready, input, 1: consumer accepts the byte in any cycle where rx_valid & rx_ready.
- parity_err, output, 1: one-cycle pulse, frame dropped for bad odd parity.
- frame_err, output, 1: one-cycle pulse, frame dropped for stop bit = 0 or timeout.
- overrun, output, 1: one-cycle pulse, good frame dropped because the holding register was full.
- ps2_clk_inhibit, output, 1: top level drives PS2_CLK low when 1 (open-drain).

Behaviour:
- Reset (async, reset_n = 0):
  - all outputs 0; FSM to IDLE; filtered clock = 1; both sync chains = 1; counters and shift register 0.
  - Reset mid-frame discards the partial frame.
- Synchronisation and filtering:
  - 2-flop synchroniser on each pin.
  - Filter counter increments while the synced clock differs from the filtered clock and clears otherwise. When it reaches FILTER_LEN, the filtered clock toggles and the counter clears.
  - Falling edge of the filtered clock produces a one-cycle fall_tick.
  - Data is sampled from the synced data line in the fall_tick cycle.
- FSM states IDLE, DATA, PARITY, STOP; transitions occur only on fall_tick, except timeout.
  - IDLE: data = 0 → DATA with bit_cnt = 0. Data = 1 → stay, no error.
  - DATA: shift the data bit in LSB-first (shreg = {d, shreg[7:1]}), bit_cnt++. After the 8th bit → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP, data = 0: frame_err pulse; → IDLE.
  - STOP, data = 1 and bad parity (XOR of the 8 data bits and the parity bit must be 1): parity_err pulse; → IDLE.
  - STOP, data = 1 and good parity: deliver the byte (see holding register); → IDLE.
  - If data = 0 and parity is bad in STOP, only frame_err is pulsed.
- Timeout:
  - Counter active in DATA/PARITY/STOP; cleared on every fall_tick and in IDLE.
  - Reaching TIMEOUT_CYCLES → frame_err pulse, → IDLE, partial byte discarded.
- Holding register:
  - Delivery when empty, or when full with rx_valid & rx_ready in the same cycle: rx_data loads next cycle and rx_valid = 1. Latency is 1 clk after the STOP fall_tick.
  - Delivery when full and not consumed that cycle: overrun pulse; new byte discarded; old rx_data unchanged.
  - Consume without delivery: rx_valid drops next cycle; rx_data holds its last value.
  - rx_ready while rx_valid = 0 is ignored.
- Inhibit (INHIBIT_EN = 1):
  - ps2_clk_inhibit is registered.
  - Set when rx_valid = 1 and FSM = IDLE, so an in-progress frame is never truncated.
  - Cleared the cycle after rx_valid falls.
  - While ps2_clk_inhibit = 1, fall_tick is ignored by the FSM. The line falling low due to the host's own drive must not start a frame.
  - After release, the filter sees the clock rise; normal reception resumes.
- Error pulses are mutually exclusive and last exactly one cycle.

Test Plan:
- Frame 0x1C:
  - Stimulus: start 0, data LSB-first 0,0,1,1,1,0,0,0, parity 0, stop 1; 40 µs clock period (2000 clk cycles).
  - Response: rx_valid = 1 and rx_data = 0x1C one clk after the stop fall_tick; no error pulses.
- Back-to-back 0xF0 then 0x1C, rx_ready held 1: two rx_valid pulses of one cycle each, data 0xF0 then 0x1C.
- Parity error: 0x1C with parity bit 1 → parity_err pulse, rx_valid stays 0. Stop bit 0 with good parity → frame_err pulse only.
- Timeout: stop the clock after 4 data bits for 100000 cycles → frame_err at cycle 100000, FSM IDLE. A following good 0x5A frame is received correctly.
- Overrun and inhibit:
  - With INHIBIT_EN = 0, rx_ready = 0, send 0x11 then 0x22 → rx_data stays 0x11, overrun pulses once.
  - With INHIBIT_EN = 1: ps2_clk_inhibit rises after 0x11 is held and drops the cycle after rx_ready consumes it.
- Glitches and reset:
  - 5-cycle low glitch on ps2_clk_in (below FILTER_LEN = 8) → no fall_tick, no state change.
  - Assert reset_n mid-frame → all outputs 0 immediately; the next full frame is received correctly.
